// File: rtl/spike_replay_pkg.sv
// spike_replay_pkg: shared state encoding and default geometry for the spike window replayer
package spike_replay_pkg;
    typedef enum logic {IDLE, PLAY} state_t;
    localparam int NUM_CH     = 16;
    localparam int NUM_BINS   = 50;
    localparam int BIN_CYCLES = 100;
    localparam int CH_W       = $clog2(NUM_CH);
    localparam int BIN_W      = $clog2(NUM_BINS);
    localparam int WIN_W      = NUM_CH * NUM_BINS;
endpackage

// File: rtl/spike_prio_enc.sv
// spike_prio_enc: combinational lowest-set-bit encoder; i_vec in, o_idx (lowest set index) and o_any out
module spike_prio_enc #(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic [N-1:0] i_vec,
    output logic [W-1:0] o_idx,
    output logic         o_any
);
    always_comb begin
        o_idx = '0;
        for (int i = N - 1; i >= 0; i--) o_idx = i_vec[i] ? W'(i) : o_idx;
    end
    assign o_any = |i_vec;
endmodule

// File: rtl/spike_window_replayer.sv
// spike_window_replayer: replays a captured bin x channel spike window as a paced event stream
//  clk/rst (async, active-high); win_valid/win_ready/win_data accept a window; abort stops playback;
//  spike_valid/spike_ready/channel_id carry events; bin_index, busy, done (pulse), overrun (sticky).
//  REPLAY_LOOP_EN adds loop_en: at the last bin end, loop_en=1 restarts from bin 0 instead of stopping.
module spike_window_replayer #(
    parameter int NUM_CH     = spike_replay_pkg::NUM_CH,
    parameter int NUM_BINS   = spike_replay_pkg::NUM_BINS,
    parameter int BIN_CYCLES = spike_replay_pkg::BIN_CYCLES,
    parameter int CH_W       = spike_replay_pkg::CH_W,
    parameter int BIN_W      = spike_replay_pkg::BIN_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       win_valid,
    output logic                       win_ready,
    input  logic [NUM_CH*NUM_BINS-1:0] win_data,
    input  logic                       abort,
    output logic                       spike_valid,
    input  logic                       spike_ready,
    output logic [CH_W-1:0]            channel_id,
    output logic [BIN_W-1:0]           bin_index,
    output logic                       busy,
    output logic                       done,
    output logic                       overrun
`ifdef REPLAY_LOOP_EN
    ,
    input  logic                       loop_en
`endif
);
    import spike_replay_pkg::*;
    localparam int TW = $clog2(BIN_CYCLES + 1);
    localparam int WW = NUM_CH * NUM_BINS;
    state_t            r_state;
    logic [WW-1:0]     r_win;
    logic [NUM_CH-1:0] r_pending;
    logic [TW-1:0]     r_timer;
    logic [BIN_W-1:0]  r_bin;
    logic              r_busy;
    logic              r_done;
    logic              r_overrun;
    logic              r_ready;
    logic [NUM_CH-1:0] w_bins [NUM_BINS];
    logic [CH_W-1:0]   w_ch;
    logic              w_any;
    logic              w_hs;
    logic [NUM_CH-1:0] w_clr;
    logic [NUM_CH-1:0] w_pend_next;
    logic              w_bin_end;
    logic              w_last;
    logic              w_loop;
    logic [BIN_W-1:0]  w_next_bin;
    for (genvar b = 0; b < NUM_BINS; b++) begin : g_bin
        assign w_bins[b] = r_win[b*NUM_CH +: NUM_CH];
    end
    spike_prio_enc #(.N(NUM_CH), .W(CH_W)) u_enc (
        .i_vec (r_pending),
        .o_idx (w_ch),
        .o_any (w_any)
    );
`ifdef REPLAY_LOOP_EN
    assign w_loop = loop_en;
`else
    assign w_loop = 1'b0;
`endif
    assign spike_valid = (r_state == PLAY) && w_any;
    assign channel_id  = w_ch;
    assign bin_index   = r_bin;
    assign busy        = r_busy;
    assign done        = r_done;
    assign overrun     = r_overrun;
    assign win_ready   = r_ready;
    assign w_hs        = spike_valid && spike_ready;
    assign w_clr       = w_hs ? (NUM_CH'(1) << w_ch) : '0;
    assign w_pend_next = r_pending & ~w_clr;
    // timer runs one past BIN_CYCLES-1; reaching BIN_CYCLES means the bin is being stretched
    assign w_bin_end   = (r_state == PLAY) && (r_timer >= TW'(BIN_CYCLES - 1)) && (w_pend_next == '0);
    assign w_last      = r_bin == BIN_W'(NUM_BINS - 1);
    assign w_next_bin  = w_last ? '0 : r_bin + BIN_W'(1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_win     <= '0;
            r_pending <= '0;
            r_timer   <= '0;
            r_bin     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
            r_ready   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (abort) begin
                r_state   <= IDLE;
                r_pending <= '0;
                r_busy    <= 1'b0;
                r_ready   <= 1'b1;
            end else if (r_state == IDLE) begin
                r_ready <= 1'b1;
                if (win_valid && r_ready) begin
                    r_state   <= PLAY;
                    r_win     <= win_data;
                    r_pending <= win_data[NUM_CH-1:0];
                    r_timer   <= '0;
                    r_bin     <= '0;
                    r_overrun <= 1'b0;
                    r_busy    <= 1'b1;
                    r_ready   <= 1'b0;
                end
            end else begin
                r_pending <= w_pend_next;
                r_timer   <= (r_timer == TW'(BIN_CYCLES)) ? r_timer : r_timer + TW'(1);
                if (w_bin_end) begin
                    r_timer <= '0;
                    r_done  <= w_last;
                    if (r_timer == TW'(BIN_CYCLES)) r_overrun <= 1'b1;
                    if (w_last && !w_loop) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                    end else begin
                        r_bin     <= w_next_bin;
                        r_pending <= w_bins[w_next_bin];
                    end
                end
            end
        end
    end
endmodule
